cmddecoder: RTL

Pin-level DDR4 command decoder that sits directly upstream of the `memtiming` bank timing FSM. It samples the command/address pins once per clock and produces one-cycle command pulses (ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, MRW, MRR, PD, PDX, CKEH, CKEL, CFG) for that FSM. It also tracks CKE history and power-down/self-refresh residency, and holds the 8-entry mode-register file. The FSM's DPD, DPDX and BST inputs are tied low at top level; DDR4 has no deep power-down.

---
 rtl/cmddecoder_if.sv | 53 +++++
 rtl/cmddecoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmddecoder_if.sv
// DDR4 command pins toward the decoder and the decoded pulses/captures back
// toward the bank timing FSM.
interface cmddecoder_if;
  logic        cke;
  logic        cs_n;
  logic        act_n;
  logic        ras_n;
  logic        cas_n;
  logic        we_n;
  logic [1:0]  bg;
  logic [1:0]  ba;
  logic [13:0] a;

  logic        ACT;
  logic        RD;
  logic        RDA;
  logic        WR;
  logic        WRA;
  logic        PR;
  logic        PRA;
  logic        REF;
  logic        SRF;
  logic        MRW;
  logic        MRR;
  logic        PD;
  logic        PDX;
  logic        CKEH;
  logic        CKEL;
  logic        CFG;
  logic        cmd_err;
  logic [1:0]  cmd_bg;
  logic [1:0]  cmd_ba;
  logic [16:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        cmd_bc4;
  logic [13:0] mr_rdata;
  logic        in_pd;
  logic        in_sr;

  modport master (
    output cke, cs_n, act_n, ras_n, cas_n, we_n, bg, ba, a,
    input  ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, MRW, MRR, PD, PDX,
           CKEH, CKEL, CFG, cmd_err, cmd_bg, cmd_ba, cmd_row, cmd_col,
           cmd_bc4, mr_rdata, in_pd, in_sr
  );

  modport slave (
    input  cke, cs_n, act_n, ras_n, cas_n, we_n, bg, ba, a,
    output ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, MRW, MRR, PD, PDX,
           CKEH, CKEL, CFG, cmd_err, cmd_bg, cmd_ba, cmd_row, cmd_col,
           cmd_bc4, mr_rdata, in_pd, in_sr
  );
endinterface

// File: rtl/cmddecoder.sv
// DDR4 pin-level command decoder: registered one-cycle command pulses, CKE
// power-state tracking and the eight-entry mode-register file.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   PWR_ACTIVE | normal operation, commands decoded when cke_q=1
//   PWR_PD     | power-down, left on the next rising cke (PDX)
//   PWR_SR     | self-refresh, left on the next rising cke (CKEH)
module cmddecoder #(
  parameter logic [13:0] MR_INIT    = 14'h0000,
  parameter bit          RFU_IS_ERR = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  cmddecoder_if.slave  bus
);

  localparam int P_ACT  = 0;
  localparam int P_RD   = 1;
  localparam int P_RDA  = 2;
  localparam int P_WR   = 3;
  localparam int P_WRA  = 4;
  localparam int P_PR   = 5;
  localparam int P_PRA  = 6;
  localparam int P_REF  = 7;
  localparam int P_SRF  = 8;
  localparam int P_MRW  = 9;
  localparam int P_MRR  = 10;
  localparam int P_PD   = 11;
  localparam int P_PDX  = 12;
  localparam int P_CKEH = 13;
  localparam int P_CKEL = 14;
  localparam int P_CFG  = 15;

  typedef enum logic [1:0] {
    PWR_ACTIVE = 2'd0,
    PWR_PD     = 2'd1,
    PWR_SR     = 2'd2
  } pwr_e;

  pwr_e        pwr_q, pwr_d;
  logic        cke_q;
  logic [15:0] pulse_q, pulse_d;
  logic        err_q, err_d;
  logic [1:0]  bg_q, bg_d;
  logic [1:0]  ba_q, ba_d;
  logic [16:0] row_q, row_d;
  logic [9:0]  col_q, col_d;
  logic        bc4_q, bc4_d;
  logic [13:0] rdata_q, rdata_d;
  logic [13:0] mr_q [8];

  logic        mr_we;
  logic [2:0]  mr_idx;
  logic        fall_err;
  logic        capture;

  logic        cmd_valid;
  logic        cke_fall;
  logic        cke_rise;
  logic        is_nop;
  logic [2:0]  rcw;
  logic        bc4_now;
  logic        mpr_mode;

  assign rcw       = {bus.ras_n, bus.cas_n, bus.we_n};
  assign cmd_valid = !bus.cs_n && cke_q;
  assign cke_fall  = cke_q && !bus.cke;
  assign cke_rise  = !cke_q && bus.cke;
  assign is_nop    = bus.act_n && (rcw == 3'b111);
  assign bc4_now   = (mr_q[0][1:0] == 2'b01) && !bus.a[12];
  assign mpr_mode  = mr_q[3][2];

  always_comb begin
    pulse_d  = '0;
    err_d    = 1'b0;
    pwr_d    = pwr_q;
    bg_d     = bg_q;
    ba_d     = ba_q;
    row_d    = row_q;
    col_d    = col_q;
    bc4_d    = bc4_q;
    rdata_d  = rdata_q;
    mr_we    = 1'b0;
    mr_idx   = {bus.bg[0], bus.ba};
    fall_err = 1'b0;
    capture  = 1'b0;

    if (cke_fall) pulse_d[P_CKEL] = 1'b1;
    if (cke_rise) pulse_d[P_CKEH] = 1'b1;

    // Chip selected while the previous cke was low: command is dropped.
    if (!bus.cs_n && !cke_q) err_d = 1'b1;

    if (cmd_valid) begin
      if (!bus.act_n) begin
        pulse_d[P_ACT] = 1'b1;
        row_d          = {rcw, bus.a};
        capture        = 1'b1;
        fall_err       = 1'b1;
      end else begin
        case (rcw)
          3'b000: begin
            pulse_d[P_MRW] = 1'b1;
            if (mr_idx <= 3'd2) pulse_d[P_CFG] = 1'b1;
            mr_we    = 1'b1;
            capture  = 1'b1;
            fall_err = 1'b1;
          end
          3'b001: begin
            if (bus.cke) begin
              pulse_d[P_REF] = 1'b1;
            end else begin
              pulse_d[P_SRF] = 1'b1;
              pwr_d          = PWR_SR;
            end
            capture = 1'b1;
          end
          3'b010: begin
            if (bus.a[10]) pulse_d[P_PRA] = 1'b1;
            else           pulse_d[P_PR]  = 1'b1;
            capture  = 1'b1;
            fall_err = 1'b1;
          end
          3'b100: begin
            if (bus.a[10]) pulse_d[P_WRA] = 1'b1;
            else           pulse_d[P_WR]  = 1'b1;
            bc4_d    = bc4_now;
            col_d    = bus.a[9:0];
            capture  = 1'b1;
            fall_err = 1'b1;
          end
          3'b101: begin
            if (mpr_mode) begin
              pulse_d[P_MRR] = 1'b1;
              rdata_d        = mr_q[{1'b0, bus.ba}];
            end else begin
              if (bus.a[10]) pulse_d[P_RDA] = 1'b1;
              else           pulse_d[P_RD]  = 1'b1;
              bc4_d = bc4_now;
            end
            col_d    = bus.a[9:0];
            capture  = 1'b1;
            fall_err = 1'b1;
          end
          3'b011: begin
            if (RFU_IS_ERR) err_d = 1'b1;
          end
          default: ;
        endcase
      end

      if (capture) begin
        bg_d = bus.bg;
        ba_d = bus.ba;
      end
      // Real commands issued on the cke falling edge are flagged, not dropped.
      if (fall_err && cke_fall) err_d = 1'b1;
    end

    if (cke_fall && (pwr_q == PWR_ACTIVE) && (bus.cs_n || is_nop)) begin
      pulse_d[P_PD] = 1'b1;
      pwr_d         = PWR_PD;
    end

    if (cke_rise) begin
      case (pwr_q)
        PWR_PD: begin
          pulse_d[P_PDX] = 1'b1;
          pwr_d          = PWR_ACTIVE;
        end
        PWR_SR:  pwr_d = PWR_ACTIVE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwr_q   <= PWR_ACTIVE;
      cke_q   <= 1'b0;
      pulse_q <= '0;
      err_q   <= 1'b0;
      bg_q    <= '0;
      ba_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      bc4_q   <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < 8; i++) mr_q[i] <= MR_INIT;
    end else begin
      pwr_q   <= pwr_d;
      cke_q   <= bus.cke;
      pulse_q <= pulse_d;
      err_q   <= err_d;
      bg_q    <= bg_d;
      ba_q    <= ba_d;
      row_q   <= row_d;
      col_q   <= col_d;
      bc4_q   <= bc4_d;
      rdata_q <= rdata_d;
      if (mr_we) mr_q[mr_idx] <= bus.a;
    end
  end

  assign bus.ACT      = pulse_q[P_ACT];
  assign bus.RD       = pulse_q[P_RD];
  assign bus.RDA      = pulse_q[P_RDA];
  assign bus.WR       = pulse_q[P_WR];
  assign bus.WRA      = pulse_q[P_WRA];
  assign bus.PR       = pulse_q[P_PR];
  assign bus.PRA      = pulse_q[P_PRA];
  assign bus.REF      = pulse_q[P_REF];
  assign bus.SRF      = pulse_q[P_SRF];
  assign bus.MRW      = pulse_q[P_MRW];
  assign bus.MRR      = pulse_q[P_MRR];
  assign bus.PD       = pulse_q[P_PD];
  assign bus.PDX      = pulse_q[P_PDX];
  assign bus.CKEH     = pulse_q[P_CKEH];
  assign bus.CKEL     = pulse_q[P_CKEL];
  assign bus.CFG      = pulse_q[P_CFG];
  assign bus.cmd_err  = err_q;
  assign bus.cmd_bg   = bg_q;
  assign bus.cmd_ba   = ba_q;
  assign bus.cmd_row  = row_q;
  assign bus.cmd_col  = col_q;
  assign bus.cmd_bc4  = bc4_q;
  assign bus.mr_rdata = rdata_q;
  assign bus.in_pd    = (pwr_q == PWR_PD);
  assign bus.in_sr    = (pwr_q == PWR_SR);

endmodule
